// File: rtl/risc_pipe_core.sv
// risc_pipe_core: parametrised 4-stage (IF/ID/EX/WB) RISC pipeline with loadable imem.
// Optional perf counters are enabled by defining RISC_PERF_CNT_EN.
module risc_pipe_core #(
   parameter int DATA_W     = 8,
   parameter int REG_ADDR_W = 2,
   parameter int PC_W       = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  im_we,
   input  logic [PC_W-1:0]       im_waddr,
   input  logic [31:0]           im_wdata,
   input  logic [REG_ADDR_W-1:0] dbg_reg_addr,
   output logic [DATA_W-1:0]     dbg_reg_data,
   output logic [PC_W-1:0]       pc_out,
   output logic                  busy,
   output logic                  halted,
   output logic                  wb_valid,
   output logic [REG_ADDR_W-1:0] wb_reg,
   output logic [DATA_W-1:0]     wb_data,
   output logic [31:0]           cyc_cnt,
   output logic [31:0]           ret_cnt
);
   localparam int NREG  = 1 << REG_ADDR_W;
   localparam int DEPTH = 1 << PC_W;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;

   state_t r_state, w_state_nxt;
   logic   r_drain;

   logic [31:0]       r_imem [DEPTH];
   logic [DATA_W-1:0] r_rf   [NREG];
   logic [PC_W-1:0]   r_pc;

   logic        r_ifid_v;
   logic [31:0] r_ifid_ins;

   logic                  r_idex_v;
   logic [3:0]            r_idex_op;
   logic [REG_ADDR_W-1:0] r_idex_rd;
   logic [DATA_W-1:0]     r_idex_a, r_idex_b, r_idex_imm;

   logic                  r_exwb_v;
   logic [REG_ADDR_W-1:0] r_exwb_rd;
   logic [DATA_W-1:0]     r_exwb_data;

   logic [3:0]            w_op;
   logic [REG_ADDR_W-1:0] w_rd, w_rs1, w_rs2;
   logic [DATA_W-1:0]     w_imm, w_a, w_b, w_alu;
   logic                  w_ex_wr, w_halt_id, w_go, w_idle_like;

   assign w_op  = r_ifid_ins[31:28];
   assign w_rd  = r_ifid_ins[24 +: REG_ADDR_W];
   assign w_rs1 = r_ifid_ins[20 +: REG_ADDR_W];
   assign w_rs2 = r_ifid_ins[16 +: REG_ADDR_W];
   assign w_imm = r_ifid_ins[DATA_W-1:0];

   assign w_idle_like = (r_state == S_IDLE) || (r_state == S_HALTED);
   assign w_go        = start && w_idle_like;
   assign w_halt_id   = (r_state == S_RUN) && r_ifid_v && (w_op == 4'hF);
   assign w_ex_wr     = r_idex_v && !r_idex_op[3] && (r_idex_op != 4'h0);

   always_comb begin
      w_alu = '0;
      case (r_idex_op)
         4'h1:    w_alu = r_idex_a + r_idex_b;
         4'h2:    w_alu = r_idex_a - r_idex_b;
         4'h3:    w_alu = r_idex_a & r_idex_b;
         4'h4:    w_alu = r_idex_a | r_idex_b;
         4'h5:    w_alu = r_idex_a ^ r_idex_b;
         4'h6:    w_alu = r_idex_imm;
         4'h7:    w_alu = r_idex_a + r_idex_imm;
         default: w_alu = '0;
      endcase
   end

   // Operand read: r0, then EX bypass, then write-through RF.
   always_comb begin
      w_a = r_rf[w_rs1];
      if (w_rs1 == '0)
         w_a = '0;
      else if (w_ex_wr && r_idex_rd == w_rs1)
         w_a = w_alu;
      else if (r_exwb_v && r_exwb_rd == w_rs1)
         w_a = r_exwb_data;
   end

   always_comb begin
      w_b = r_rf[w_rs2];
      if (w_rs2 == '0)
         w_b = '0;
      else if (w_ex_wr && r_idex_rd == w_rs2)
         w_b = w_alu;
      else if (r_exwb_v && r_exwb_rd == w_rs2)
         w_b = r_exwb_data;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_HALTED: if (start) w_state_nxt = S_RUN;
         S_RUN:            if (w_halt_id) w_state_nxt = S_DRAIN;
         S_DRAIN:          if (r_drain) w_state_nxt = S_HALTED;
         default:          w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (im_we && w_idle_like)
         r_imem[im_waddr] <= im_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_drain     <= 1'b0;
         r_pc        <= '0;
         r_ifid_v    <= 1'b0;
         r_ifid_ins  <= '0;
         r_idex_v    <= 1'b0;
         r_idex_op   <= '0;
         r_idex_rd   <= '0;
         r_idex_a    <= '0;
         r_idex_b    <= '0;
         r_idex_imm  <= '0;
         r_exwb_v    <= 1'b0;
         r_exwb_rd   <= '0;
         r_exwb_data <= '0;
         for (int i = 0; i < NREG; i++)
            r_rf[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_drain <= (r_state == S_DRAIN) ? ~r_drain : 1'b0;
         if (r_exwb_v && r_exwb_rd != '0)
            r_rf[r_exwb_rd] <= r_exwb_data;
         if (w_go) begin
            r_pc     <= '0;
            r_ifid_v <= 1'b0;
            r_idex_v <= 1'b0;
            r_exwb_v <= 1'b0;
         end else if (busy) begin
            r_idex_v    <= r_ifid_v;
            r_idex_op   <= w_op;
            r_idex_rd   <= w_rd;
            r_idex_a    <= w_a;
            r_idex_b    <= w_b;
            r_idex_imm  <= w_imm;
            r_exwb_v    <= w_ex_wr;
            r_exwb_rd   <= w_ex_wr ? r_idex_rd : '0;
            r_exwb_data <= w_ex_wr ? w_alu : '0;
            r_ifid_v    <= 1'b0;
            if (r_state == S_RUN) begin
               r_pc <= r_pc + 1'b1;
               if (!w_halt_id) begin
                  r_ifid_v   <= 1'b1;
                  r_ifid_ins <= r_imem[r_pc];
               end
            end
         end
      end
   end

   assign pc_out       = r_pc;
   assign busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign halted       = (r_state == S_HALTED);
   assign wb_valid     = r_exwb_v;
   assign wb_reg       = r_exwb_rd;
   assign wb_data      = r_exwb_data;
   assign dbg_reg_data = (dbg_reg_addr == '0) ? '0 : r_rf[dbg_reg_addr];

`ifdef RISC_PERF_CNT_EN
   logic [31:0] r_cyc, r_ret;
   always_ff @(posedge clk) begin
      if (reset || w_go) begin
         r_cyc <= '0;
         r_ret <= '0;
      end else begin
         if (busy)     r_cyc <= r_cyc + 32'd1;
         if (wb_valid) r_ret <= r_ret + 32'd1;
      end
   end
   assign cyc_cnt = r_cyc;
   assign ret_cnt = r_ret;
`else
   assign cyc_cnt = '0;
   assign ret_cnt = '0;
`endif
endmodule
